// File: rtl/ysyx_25070198_mem_arb.sv
// ysyx_25070198_mem_arb: IFU/LSU to single memory port arbiter, one transaction outstanding.
// Define ARB_RR_EN for round-robin on conflicts; default is fixed LSU priority.
module ysyx_25070198_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nxt;
    logic grant, last_grant, pick_lsu, accept, resp_hit;
`ifdef ARB_RR_EN
    assign pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_grant);
`else
    // last_grant is tracked but never changes the fixed-priority outcome
    assign pick_lsu = lsu_req_valid | (lsu_req_valid & last_grant);
`endif
    assign accept        = state == IDLE && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready = state == IDLE && ifu_req_valid && !pick_lsu;
    assign lsu_req_ready = state == IDLE && pick_lsu;
    assign resp_hit      = state == WAIT && mem_resp_valid;
    assign mem_req_valid = state == REQ;
    assign ifu_resp_valid = resp_hit && !grant;
    assign lsu_resp_valid = resp_hit && grant;
    assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    assign lsu_resp_data  = (lsu_resp_valid && !mem_req_wen) ? mem_resp_data : '0;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? REQ : IDLE;
            REQ:     state_nxt = mem_req_ready ? WAIT : REQ;
            WAIT:    state_nxt = mem_resp_valid ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant         <= pick_lsu;
                mem_req_addr  <= pick_lsu ? lsu_req_addr : ifu_req_addr;
                mem_req_wen   <= pick_lsu && lsu_req_wen;
                mem_req_wdata <= pick_lsu ? lsu_req_wdata : '0;
                mem_req_wmask <= pick_lsu ? lsu_req_wmask : '0;
            end
            if (resp_hit)
                last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_ysyx_25070198_mem_arb.sv
// tb_ysyx_25070198_mem_arb: directed self-checking bench for the memory arbiter.
module tb_ysyx_25070198_mem_arb;
    logic        clk = 0, rst = 1;
    logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_req_addr = 0, ifu_resp_data;
    logic        lsu_req_valid = 0, lsu_req_ready, lsu_req_wen = 0, lsu_resp_valid;
    logic [31:0] lsu_req_addr = 0, lsu_req_wdata = 0, lsu_resp_data;
    logic [3:0]  lsu_req_wmask = 0, mem_req_wmask;
    logic        mem_req_valid, mem_req_ready = 0, mem_req_wen, mem_resp_valid = 0;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data = 0;
    int pass_cnt = 0, total = 0;
    logic g;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    ysyx_25070198_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // One read transaction from the current IDLE cycle; returns grant (1 = LSU).
    task automatic xact(input logic [31:0] rdata, input logic drop, output logic gr);
        logic [31:0] exp_addr;
        #1;
        chk("one_ready", 32'(ifu_req_ready ^ lsu_req_ready), 1);
        gr = lsu_req_ready;
        exp_addr = gr ? lsu_req_addr : ifu_req_addr;
        tick;
        if (drop && gr) lsu_req_valid = 0;
        if (drop && !gr) ifu_req_valid = 0;
        mem_req_ready = 1;
        #1;
        chk("x_req_valid", 32'(mem_req_valid), 1);
        chk("x_req_addr", mem_req_addr, exp_addr);
        chk("x_busy_ready", 32'(ifu_req_ready | lsu_req_ready), 0);
        tick;
        mem_resp_valid = 1;
        mem_resp_data = rdata;
        #1;
        chk("x_ifu_resp", 32'(ifu_resp_valid), 32'(!gr));
        chk("x_lsu_resp", 32'(lsu_resp_valid), 32'(gr));
        chk("x_resp_data", gr ? lsu_resp_data : ifu_resp_data, rdata);
        tick;
        mem_resp_valid = 0;
        mem_resp_data = 0;
        #1;
        chk("x_resp_clr", 32'(ifu_resp_valid | lsu_resp_valid), 0);
    endtask
    initial begin
        repeat (2) tick;
        rst = 0;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_resp", 32'(ifu_resp_valid | lsu_resp_valid), 0);
        chk("rst_ready", 32'(ifu_req_ready | lsu_req_ready), 0);
        // IFU alone
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
        #1;
        chk("ifu_ready", 32'(ifu_req_ready), 1);
        chk("ifu_lsu_ready", 32'(lsu_req_ready), 0);
        tick;
        ifu_req_valid = 0; ifu_req_addr = 32'h1;
        chk("ifu_mreq", 32'(mem_req_valid), 1);
        chk("ifu_maddr", mem_req_addr, 32'h8000_0000);
        chk("ifu_mwen", 32'(mem_req_wen), 0);
        chk("ifu_mmask", 32'(mem_req_wmask), 0);
        tick;
        mem_resp_valid = 1; mem_resp_data = 32'h0010_0073;
        #1;
        chk("ifu_resp_v", 32'(ifu_resp_valid), 1);
        chk("ifu_resp_d", ifu_resp_data, 32'h0010_0073);
        chk("ifu_lsu_resp", 32'(lsu_resp_valid), 0);
        tick;
        mem_resp_valid = 0; mem_resp_data = 0;
        #1;
        chk("ifu_resp_pulse", 32'(ifu_resp_valid), 0);
        // LSU write with three stall cycles
        mem_req_ready = 0;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
        #1;
        chk("wr_ready", 32'(lsu_req_ready), 1);
        tick;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_mreq", 32'(mem_req_valid), 1);
            chk("wr_maddr", mem_req_addr, 32'h8000_1000);
            chk("wr_mwdata", mem_req_wdata, 32'hDEAD_BEEF);
            chk("wr_mmask", 32'(mem_req_wmask), 32'hF);
            chk("wr_mwen", 32'(mem_req_wen), 1);
            if (i == 3) mem_req_ready = 1;
            tick;
        end
        chk("wr_wait", 32'(mem_req_valid), 0);
        mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
        #1;
        chk("wr_resp_v", 32'(lsu_resp_valid), 1);
        chk("wr_resp_d", lsu_resp_data, 0);
        chk("wr_ifu_resp", 32'(ifu_resp_valid), 0);
        tick;
        mem_resp_valid = 0; mem_resp_data = 0;
        // Simultaneous requests, each master drops after being served
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000;
        xact(32'hAAAA_0001, 1'b1, g);
        chk("conf_first", 32'(g), RR ? 0 : 1);
        xact(32'hAAAA_0002, 1'b1, g);
        chk("conf_second", 32'(g), RR ? 1 : 0);
        // Continuous contention for four transactions
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            xact(32'hB000_0000 + 32'(i), 1'b0, g);
            chk("cont_grant", 32'(g), RR ? 32'(i % 2) : 1);
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        // Reset while in WAIT, then a stray response
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
        tick;
        ifu_req_valid = 0;
        tick;
        rst = 1;
        tick;
        rst = 0;
        mem_resp_valid = 1; mem_resp_data = 32'hFFFF_FFFF;
        #1;
        chk("rstw_resp", 32'(ifu_resp_valid | lsu_resp_valid), 0);
        chk("rstw_mreq", 32'(mem_req_valid), 0);
        tick;
        mem_resp_valid = 0;
        ifu_req_addr = 32'h8000_0010; ifu_req_valid = 1;
        xact(32'h0000_0013, 1'b1, g);
        chk("rstw_after", 32'(g), 0);
        // Stray response while idle with nothing pending
        mem_resp_valid = 1; mem_resp_data = 32'h5555_5555;
        #1;
        chk("idle_resp", 32'(ifu_resp_valid | lsu_resp_valid), 0);
        tick;
        mem_resp_valid = 0;
        #1;
        chk("idle_mreq", 32'(mem_req_valid), 0);
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_3000;
        #1;
        chk("idle_still", 32'(lsu_req_ready), 1);
        xact(32'hC0FF_EE00, 1'b1, g);
        chk("idle_after", 32'(g), 1);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/ysyx_25070198_mem_arb.md
# ysyx_25070198_mem_arb

Two-master, one-slave memory arbiter that shares the single memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). Sits between the IFU/LSU and the memory backend (DPI-C bridge now, AXI bridge later). Masters use a valid/ready request channel and a single-cycle response pulse. The arbiter holds at most one outstanding transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (mask width is DATA_W/8)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid (1-cycle pulse)
- ifu_resp_data  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  LSU response (read data or write ack), 1-cycle pulse
- lsu_resp_data  out  DATA_W  LSU read data (0 on write ack)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  registered address
- mem_req_wen  out  1  registered write enable
- mem_req_wdata  out  DATA_W  registered write data
- mem_req_wmask  out  DATA_W/8  registered mask
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: state, grant (0 = IFU, 1 = LSU), request latch (addr, wen, wdata, wmask), last_grant.
- IDLE: if any req_valid, select a winner. Its req_ready is 1 combinationally this cycle; the loser's is 0. On the edge, latch the winner's fields and grant, then go to REQ. IFU latches wen = 0, wmask = 0, wdata = 0.
- REQ: mem_req_valid = 1 with the latched fields. Go to WAIT on the edge where mem_req_ready = 1.
- WAIT: on mem_resp_valid = 1, raise the granted master's resp_valid for that cycle. resp_data = mem_resp_data for reads, 0 for LSU writes. Return to IDLE on the same edge and update last_grant.
- Both req_ready are 0 outside IDLE. Masters hold valid and fields stable until ready.
- Default arbitration: fixed priority, LSU wins over IFU.
- mem_resp_valid seen in IDLE or REQ is ignored and not routed.
- The non-granted master's resp_valid is 0 at all times.

## Timing
- Reset values: state = IDLE, grant = 0, last_grant = 1 (LSU), latch = 0. All outputs 0 except req_ready, which follows IDLE logic combinationally after reset.
- Minimum latency: accept at edge N, mem_req_valid high in cycle N+1, response routed earliest in cycle N+2, next accept earliest in cycle N+3.
- mem_req_ready stall: mem_req_valid and fields stay constant in REQ.
- Reset mid-transaction (REQ or WAIT): return to IDLE next edge. The outstanding transaction is dropped with no response. A later stray mem_resp_valid is ignored.
- Simultaneous requests in IDLE are resolved the same cycle; exactly one ready.

## Configuration
- ARB_RR_EN defined: round-robin arbitration. On a conflict in IDLE, the grant goes to the master not equal to last_grant. An uncontested request always wins.
- ARB_RR_EN undefined: fixed LSU priority; last_grant exists but does not affect arbitration.

## Test plan
- IFU alone reads addr 0x80000000, mem_req_ready = 1, memory responds 0x00100073 one cycle later -> ifu_resp_valid pulses 1 cycle with 0x00100073; accept-to-response takes 2 cycles.
- LSU write to 0x80001000, wdata 0xDEADBEEF, wmask 0xF, with mem_req_ready held low 3 cycles -> mem_req_* stable for 4 cycles; lsu_resp_valid pulses with data 0; no IFU response.
- Both request in the same IDLE cycle, default build -> lsu_req_ready = 1, ifu_req_ready = 0; IFU is granted in the next IDLE.
- Both request continuously for 4 transactions with ARB_RR_EN -> grant order IFU, LSU, IFU, LSU. Without the macro -> LSU on all 4.
- Assert rst in WAIT, then pulse mem_resp_valid -> state IDLE, no resp_valid on either master; a following IFU request completes normally.
- mem_resp_valid pulsed while in IDLE with no request -> both resp_valid stay 0; state stays IDLE.
